// File: rtl/linebuf_window_ctrl.sv
// linebuf_window_ctrl: sequencing controller for the mean-filter line-buffer
// chain. Tracks raster position, drives the common line-buffer shift enable,
// and presents a registered, tagged window descriptor once a full WIN x WIN
// neighbourhood sits at the buffer outputs.
//
// Optional feature macro: LBWIN_BORDER_EN
//   defined   - every accepted pixel yields a window; win_border marks edge ones
//   undefined - only interior windows are emitted; win_border is tied 0
module linebuf_window_ctrl #(
  parameter  int IMG_W = 640,
  parameter  int IMG_H = 480,
  parameter  int WIN   = 3,
  localparam int CW    = $clog2(IMG_W),
  localparam int RW    = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_sof,
  output logic          in_ready,
  output logic          lb_en,
  input  logic          out_ready,
  output logic          win_valid,
  output logic [CW-1:0] win_col,
  output logic [RW-1:0] win_row,
  output logic          win_eol,
  output logic          win_eof,
  output logic          win_border,
  output logic          frame_done,
  output logic          err_sof
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(WIN - 1);
  localparam logic [RW-1:0] ROW_WIN  = RW'(WIN - 1);

  state_t        state;
  logic [CW-1:0] col;   // position of the next pixel to arrive
  logic [RW-1:0] row;

  logic          tail;       // final window of the frame still in the output register
  logic          idle_like;  // between frames: only in_sof starts real work
  logic          accept;
  logic          restart;
  logic [CW-1:0] pix_col;    // position of the pixel being accepted now
  logic [RW-1:0] pix_row;
  logic [CW-1:0] nxt_col;
  logic [RW-1:0] nxt_row;
  logic          emit;
  logic          emit_border;

  // Handshake, pixel position and window qualification for the current cycle.
  // NOTE: every always_comb output gets a default first so no path can leave it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    tail        = 1'b0;
    idle_like   = 1'b0;
    pix_col     = col;
    pix_row     = row;
    nxt_col     = col;
    nxt_row     = row;
    emit        = 1'b0;
    emit_border = 1'b0;

    // The STREAM -> IDLE step happens only once the eof window leaves the
    // output register, so the frame tail behaves like IDLE for new pixels.
    tail      = (state == STREAM) & win_valid & win_eof;
    idle_like = (state == IDLE) | tail;

    in_ready = (state == IDLE) | ~win_valid | out_ready;
    accept   = in_valid & in_ready;
    // Pixels between frames are consumed but never enter the line buffers.
    lb_en    = accept & (~idle_like | in_sof);
    restart  = lb_en & in_sof;

    // A start-of-frame pixel is always (0,0), whether it opens a frame or
    // aborts one mid-way.
    if (idle_like || in_sof) begin
      pix_col = '0;
      pix_row = '0;
    end

    if (pix_col == COL_LAST) begin
      nxt_col = '0;
      nxt_row = (pix_row == ROW_LAST) ? '0 : pix_row + RW'(1);
    end else begin
      nxt_col = pix_col + CW'(1);
      nxt_row = pix_row;
    end

`ifdef LBWIN_BORDER_EN
    emit        = lb_en;
    emit_border = (pix_row < ROW_WIN) | (pix_col < COL_WIN);
`else
    // STREAM guarantees row >= WIN-1; a restart pixel sits at column 0 and so
    // never qualifies.
    emit        = lb_en & (state == STREAM) & (pix_col >= COL_WIN);
    emit_border = 1'b0;
`endif
  end

  // Frame FSM, position counters, window output register and status flags.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      win_valid  <= 1'b0;
      win_col    <= '0;
      win_row    <= '0;
      win_eol    <= 1'b0;
      win_eof    <= 1'b0;
      win_border <= 1'b0;
      frame_done <= 1'b0;
      err_sof    <= 1'b0;
    end else begin
      frame_done <= win_valid & out_ready & win_eof;

      if (restart && !idle_like) begin
        err_sof <= 1'b1;
      end

      if (lb_en) begin
        col <= nxt_col;
        row <= nxt_row;
        if (restart) begin
          state <= PRIME;
        end else if (state == PRIME && nxt_row == ROW_WIN) begin
          state <= STREAM;
        end
      end else if (tail && out_ready) begin
        state <= IDLE;
      end

      // Hold the descriptor while the downstream stage stalls; otherwise load
      // the window qualified by this cycle's pixel, or drop win_valid.
      if (!win_valid || out_ready) begin
        win_valid <= emit;
        if (emit) begin
          win_col    <= pix_col;
          win_row    <= pix_row;
          win_eol    <= (pix_col == COL_LAST);
          win_eof    <= (pix_col == COL_LAST) & (pix_row == ROW_LAST);
          win_border <= emit_border;
        end
      end
    end
  end

endmodule

// File: tb/tb_linebuf_window_ctrl.sv
// Self-checking bench for linebuf_window_ctrl on an 8x6 frame with WIN=3.
// Expected windows are queued as pixels are issued; a negedge monitor pops and
// compares them whenever a window handshake is presented.
// Build with LBWIN_BORDER_EN defined to check the border-window variant.
module tb_linebuf_window_ctrl;

  localparam int W = 8;
  localparam int H = 6;
  localparam int K = 3;

`ifdef LBWIN_BORDER_EN
  localparam bit BM = 1'b1;
`else
  localparam bit BM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_sof;
  logic       in_ready;
  logic       lb_en;
  logic       out_ready = 1'b1;
  logic       win_valid;
  logic [2:0] win_col;
  logic [2:0] win_row;
  logic       win_eol;
  logic       win_eof;
  logic       win_border;
  logic       frame_done;
  logic       err_sof;

  linebuf_window_ctrl #(.IMG_W(W), .IMG_H(H), .WIN(K)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_ready   (in_ready),
    .lb_en      (lb_en),
    .out_ready  (out_ready),
    .win_valid  (win_valid),
    .win_col    (win_col),
    .win_row    (win_row),
    .win_eol    (win_eol),
    .win_eof    (win_eof),
    .win_border (win_border),
    .frame_done (frame_done),
    .err_sof    (err_sof)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] col;
    logic [2:0] row;
    logic       eol;
    logic       eof;
    logic       border;
  } win_t;

  win_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_win, n_eol, n_eof, n_border, n_lben, n_fd;
  bit   rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_counts();
    n_win = 0; n_eol = 0; n_eof = 0; n_border = 0; n_lben = 0; n_fd = 0;
  endtask

  // Downstream acceptance: always ready, or a 50% coin flip per cycle.
  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: window scoreboard, stall stability, lb_en gating, frame_done.
  win_t cur, held, e;
  bit   stalled = 1'b0;
  bit   exp_fd  = 1'b0;
  always @(negedge clk) begin
    cur = {win_col, win_row, win_eol, win_eof, win_border};
    check("frame_done", frame_done, exp_fd);
    exp_fd = 1'b0;
    if (lb_en) n_lben++;
    if (frame_done) n_fd++;
    if (win_valid && !out_ready) check("lb_en_while_stalled", lb_en, 0);
    if (stalled) begin
      check("hold_valid", win_valid, 1);
      check("hold_fields", cur, held);
    end
    stalled = win_valid & ~out_ready;
    held    = cur;
    if (win_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_window: got col %0d row %0d, expected none", win_col, win_row);
      end else begin
        e = exp_q.pop_front();
        check("win_fields", cur, e);
        n_win++;
        if (win_eol) n_eol++;
        if (win_eof) n_eof++;
        if (win_border) n_border++;
        exp_fd = e.eof;
      end
    end
  end

  // Present one pixel and hold it until the DUT accepts it.
  task automatic push_pix(input logic sof);
    int t = 0;
    in_valid = 1'b1;
    in_sof   = sof;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 1000) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got in_ready 0 for %0d cycles, expected 1", t);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // Issue raster indices lo..hi-1 (index 0 carries in_sof), queueing the
  // windows each one should produce.
  task automatic run_pixels(input int lo, input int hi, input int gap_max);
    for (int i = lo; i < hi; i++) begin
      int   c = i % W;
      int   r = i / W;
      logic em;
      win_t w;
      em       = BM ? 1'b1 : ((c >= K - 1) && (r >= K - 1));
      w.col    = 3'(c);
      w.row    = 3'(r);
      w.eol    = (c == W - 1);
      w.eof    = (c == W - 1) && (r == H - 1);
      w.border = BM && ((c < K - 1) || (r < K - 1));
      if (em) exp_q.push_back(w);
      push_pix(i == 0);
      check("win_valid_1cyc", win_valid, em);
      if (gap_max > 0) begin
        int g = $urandom_range(0, gap_max);
        if (g > 0) begin
          repeat (g) @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d windows outstanding, expected 0", exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", in_ready, 1);
    check("rst_win_valid", win_valid, 0);
    check("rst_win_col", win_col, 0);
    check("rst_win_row", win_row, 0);
    check("rst_win_eol", win_eol, 0);
    check("rst_win_eof", win_eof, 0);
    check("rst_win_border", win_border, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err_sof", err_sof, 0);
  endtask

  task automatic check_frame(input string tag, input int frames);
    check({tag, "_windows"}, n_win, frames * (BM ? 48 : 24));
    check({tag, "_eol"}, n_eol, frames * (BM ? 6 : 4));
    check({tag, "_eof"}, n_eof, frames);
    check({tag, "_border"}, n_border, frames * (BM ? 24 : 0));
    check({tag, "_lb_en"}, n_lben, frames * 48);
    check({tag, "_frame_done"}, n_fd, frames);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    check("rst_lb_en", lb_en, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // One frame, continuous valid, always ready.
    clear_counts();
    run_pixels(0, W * H, 0);
    drain();
    check_frame("frame1", 1);

    // Two frames back to back: the next in_sof overlaps the final window.
    clear_counts();
    run_pixels(0, W * H, 0);
    run_pixels(0, W * H, 0);
    drain();
    check_frame("b2b", 2);

    // Random input gaps and random downstream backpressure.
    rand_ready = 1'b1;
    clear_counts();
    run_pixels(0, W * H, 3);
    drain();
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_frame("random", 1);

    // Pixels without in_sof while idle are swallowed.
    clear_counts();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_sof   = 1'b0;
      @(negedge clk);
      check("idle_in_ready", in_ready, 1);
      check("idle_lb_en", lb_en, 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_windows", n_win, 0);
    check("idle_lb_en_count", n_lben, 0);
    check("idle_err_sof", err_sof, 0);

    // in_sof at pixel (5,3): sticky error, restart, full frame afterwards.
    clear_counts();
    run_pixels(0, 3 * W + 5, 0);
    run_pixels(0, W * H, 0);
    drain();
    check("abort_err_sof", err_sof, 1);
    check("abort_windows", n_win, BM ? 77 : 33);
    check("abort_lb_en", n_lben, 77);
    check("abort_frame_done", n_fd, 1);
    check("abort_eof", n_eof, 1);

    // Reset in STREAM with pixel (4,4) next, then a clean frame.
    clear_counts();
    run_pixels(0, 4 * W + 4, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values();
    check("rst_queue_empty", exp_q.size(), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    clear_counts();
    run_pixels(0, W * H, 0);
    drain();
    check_frame("post_rst", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
